// File: rtl/pipe_ctrl_defs_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// the packed per-stage control bus and the RUN-rule control decode.
package pipe_ctrl_defs;

    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_HALT     = 2'd3;

    // MSB-first bit ordering of the control bus
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = 7'b000_0000;
    localparam ctrl_t CTRL_FLUSH  = 7'b001_0100;
    localparam ctrl_t CTRL_ADV    = 7'b110_1011;
    localparam ctrl_t CTRL_BRANCH = 7'b111_1111;
    localparam ctrl_t CTRL_BUBBLE = 7'b000_0111;

    // Branch outranks load-use: the dependent instruction is being flushed anyway.
    function automatic ctrl_t run_ctrl(input logic branch, input logic load_use);
        if (branch)
            return CTRL_BRANCH;
        else if (load_use)
            return CTRL_BUBBLE;
        else
            return CTRL_ADV;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count_q <= '0;
        else if (inc && !(&count_q))
            count_q <= count_q + 1'b1;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges load-use,
// branch, memory-wait and halt requests into per-stage enable/flush controls.
module pipeline_ctrl
    import pipe_ctrl_defs::*;
#(
    parameter int RESET_HOLD  = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             halted,
    output logic             mem_err,
    output logic             mem_err_sticky,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD - 1);
    // The entering RUN cycle already counts as a wait cycle, so the forced
    // release lands on stalled cycle MEM_TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] wait_q, wait_d;
    logic       halted_q, mem_err_q, sticky_q;
    logic       advance, timeout;
    ctrl_t      ctrl;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wait_d  = wait_q;
        advance = 1'b0;
        timeout = 1'b0;
        ctrl    = CTRL_FREEZE;
        case (state_q)
            ST_INIT: begin
                ctrl   = CTRL_FLUSH;
                hold_d = hold_q + 8'd1;
                if (hold_q >= HOLD_LAST)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    wait_d  = 8'd1;
                    state_d = ST_MEM_WAIT;
                end else begin
                    advance = 1'b1;
                    if (halt_req)
                        state_d = ST_HALT;
                end
            end
            ST_MEM_WAIT: begin
                wait_d  = wait_q + 8'd1;
                timeout = !mem_ready && (wait_q >= WAIT_LAST);
                if (mem_ready || timeout) begin
                    advance = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (resume)
                    state_d = ST_RUN;
            end
        endcase
        if (advance)
            ctrl = run_ctrl(branch_taken, load_use);
        if (!rst_n)
            ctrl = CTRL_FLUSH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            hold_q    <= '0;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            mem_err_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            wait_q    <= wait_d;
            halted_q  <= (state_d == ST_HALT);
            mem_err_q <= timeout;
            sticky_q  <= sticky_q | timeout;
        end
    end

    logic stall_inc, flush_inc;
    assign stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !ctrl.pc_en;
    assign flush_inc = advance && branch_taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign pc_en          = ctrl.pc_en;
    assign if_id_en       = ctrl.if_id_en;
    assign if_id_flush    = ctrl.if_id_flush;
    assign id_ex_en       = ctrl.id_ex_en;
    assign id_ex_flush    = ctrl.id_ex_flush;
    assign ex_mem_en      = ctrl.ex_mem_en;
    assign mem_wb_en      = ctrl.mem_wb_en;
    assign halted         = halted_q;
    assign mem_err        = mem_err_q;
    assign mem_err_sticky = sticky_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle expected control words go
// through a scoreboard queue; registered flags/counters are checked directly.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, load_use, branch_taken, mem_req, mem_ready, halt_req, resume;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic halted, mem_err, mem_err_sticky;
    logic [3:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.RESET_HOLD(4), .MEM_TIMEOUT(16), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_use       (load_use),
        .branch_taken   (branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .halt_req       (halt_req),
        .resume         (resume),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_en       (id_ex_en),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .halted         (halted),
        .mem_err        (mem_err),
        .mem_err_sticky (mem_err_sticky),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
    localparam logic [6:0] E_FRZ = 7'b000_0000;
    localparam logic [6:0] E_FLS = 7'b001_0100;
    localparam logic [6:0] E_RUN = 7'b110_1011;
    localparam logic [6:0] E_BR  = 7'b111_1111;
    localparam logic [6:0] E_LU  = 7'b000_0111;
    localparam logic [6:0] M_ALL = 7'b111_1111;
    localparam logic [6:0] M_LU  = 7'b111_0111;  // id_ex_en is moot under id_ex_flush

    int vecs = 0;
    int errs = 0;
    logic [6:0] exp_q[$];
    logic [6:0] msk_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic lu, input logic br,
                        input logic mr, input logic rdy, input logic hr, input logic rs,
                        input logic [6:0] exp, input logic [6:0] msk);
        logic [6:0] e, m, obs;
        @(posedge clk);
        #1;
        rst_n = r; load_use = lu; branch_taken = br;
        mem_req = mr; mem_ready = rdy; halt_req = hr; resume = rs;
        exp_q.push_back(exp);
        msk_q.push_back(msk);
        #3;
        obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        chk(tag, 32'(obs & m), 32'(e & m));
    endtask

    task automatic idle(input string tag, input logic [6:0] exp);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp, M_ALL);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++)
            step("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_FLS, M_ALL);
        for (int i = 0; i < 4; i++)
            idle("init_flush", E_FLS);
    endtask

    initial begin
        rst_n = 1'b0; load_use = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
        mem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0;

        // reset release and post-reset hold; request inputs ignored in INIT
        for (int i = 0; i < 3; i++)
            step("rst_hold", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_FLS, M_ALL);
        for (int i = 0; i < 4; i++)
            step("init_flush", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, E_FLS, M_ALL);
        idle("first_run", E_RUN);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_sticky", 32'(mem_err_sticky), 0);

        // load-use bubble
        step("load_use", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_LU, M_LU);
        idle("after_lu", E_RUN);
        chk("lu_stall_cnt", 32'(stall_cnt), 1);

        // branch outranks load-use
        step("br_and_lu", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_BR, M_ALL);
        idle("after_br", E_RUN);
        chk("br_flush_cnt", 32'(flush_cnt), 1);
        chk("br_stall_cnt", 32'(stall_cnt), 1);

        // memory wait: 3 frozen cycles then advance; branch ignored while frozen
        step("mem_wait0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_FRZ, M_ALL);
        step("mem_wait1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_FRZ, M_ALL);
        step("mem_wait2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_FRZ, M_ALL);
        step("mem_ready", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_RUN, M_ALL);
        idle("after_mem", E_RUN);
        chk("mem_stall_cnt", 32'(stall_cnt), 4);
        chk("mem_flush_cnt", 32'(flush_cnt), 1);
        chk("mem_no_err", 32'(mem_err_sticky), 0);

        // halt / resume
        step("halt_req", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_RUN, M_ALL);
        chk("halt_not_yet", 32'(halted), 0);
        step("in_halt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ, M_ALL);
        chk("halted_set", 32'(halted), 1);
        step("resume", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_FRZ, M_ALL);
        chk("halted_still", 32'(halted), 1);
        idle("after_resume", E_RUN);
        chk("halted_clr", 32'(halted), 0);
        chk("halt_stall_cnt", 32'(stall_cnt), 4);

        // halt together with a memory stall: MEM_WAIT wins, halt not latched
        step("halt_mem", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_FRZ, M_ALL);
        step("halt_mem_rdy", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_RUN, M_ALL);
        idle("halt_mem_run", E_RUN);
        chk("halt_mem_halted", 32'(halted), 0);
        chk("halt_mem_stall", 32'(stall_cnt), 5);

        // memory timeout
        do_reset();
        idle("to_run", E_RUN);
        chk("to_rst_sticky", 32'(mem_err_sticky), 0);
        for (int i = 0; i < 15; i++)
            step("to_wait", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_FRZ, M_ALL);
        step("to_force", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN, M_ALL);
        chk("to_err_early", 32'(mem_err), 0);
        idle("to_after", E_RUN);
        chk("to_err_pulse", 32'(mem_err), 1);
        chk("to_sticky", 32'(mem_err_sticky), 1);
        chk("to_stall_cnt", 32'(stall_cnt), 15);
        idle("to_after2", E_RUN);
        chk("to_err_clear", 32'(mem_err), 0);
        chk("to_sticky_hold", 32'(mem_err_sticky), 1);

        // saturation: 20 load-use cycles on a 4-bit counter
        do_reset();
        idle("sat_run", E_RUN);
        chk("sat_sticky_rst", 32'(mem_err_sticky), 0);
        for (int i = 0; i < 20; i++)
            step("sat_lu", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_LU, M_LU);
        idle("sat_after", E_RUN);
        chk("sat_stall_cnt", 32'(stall_cnt), 15);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Merges four request sources into one consistent set of per-stage enable and flush controls:
  - load-use stall from the forwarding/hazard unit;
  - taken branch/jump from EX;
  - data-memory/IO wait handshake from MEM;
  - external halt/resume.
- Adds a post-reset hold and a memory-wait timeout, and keeps saturating performance counters.

Parameters:
- RESET_HOLD, 4: cycles the pipeline is held flushed after reset release (range 1..255).
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before a forced release with an error flag (range 2..255).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load_use  in  1  load-use hazard from the forwarding/hazard unit (ID instruction needs the EX load result).
- branch_taken  in  1  EX resolved a taken branch/jump; PC is loading the target this cycle.
- mem_req  in  1  MEM stage holds a load or store.
- mem_ready  in  1  data memory/IO completes the MEM access this cycle.
- halt_req  in  1  request to freeze the pipeline.
- resume  in  1  leave HALT.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID synchronous clear to NOP.
- id_ex_en  out  1  ID/EX register enable.
- id_ex_flush  out  1  ID/EX synchronous clear to NOP.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- halted  out  1  registered; 1 while in HALT.
- mem_err  out  1  registered one-cycle pulse on a memory timeout.
- mem_err_sticky  out  1  set on a timeout, cleared only by reset.
- stall_cnt  out  CNT_W  cycles with pc_en=0 while in RUN or MEM_WAIT; saturates at all-ones.
- flush_cnt  out  CNT_W  branch flushes taken; saturates at all-ones.

Behaviour:
- **Register rule:** flush takes precedence over enable at every pipeline register.
- **Output timing:** all enable and flush outputs are combinational from the current state and current inputs, so they act in the same cycle. State, counters and flags are registered.
- **Reset** (rst_n=0 at an edge):
  - state<=INIT, hold counter<=0, wait counter<=0.
  - halted=0, mem_err=0, mem_err_sticky=0, stall_cnt=0, flush_cnt=0.
  - While rst_n=0: all enables 0, if_id_flush=1, id_ex_flush=1.
  - Reset asserted in any state aborts it immediately.
- **INIT:**
  - All enables 0, both flushes 1.
  - Hold counter increments each cycle; after RESET_HOLD cycles, next state is RUN.
  - All request inputs are ignored.
- **RUN, priority from highest to lowest:**
  1. mem_req=1 and mem_ready=0: all enables 0, no flush. Wait counter<=1, go to MEM_WAIT.
  2. branch_taken=1: all enables 1, if_id_flush=1, id_ex_flush=1. flush_cnt+1. load_use is ignored, because the dependent instruction is being flushed.
  3. load_use=1: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=1, mem_wb_en=1. This inserts one bubble per asserted cycle.
  4. Otherwise: all enables 1, no flush.
- **Halt from RUN:**
  - halt_req=1 in RUN (and not in case 1) lets the current cycle proceed per cases 2–4, then moves to HALT.
  - If case 1 also holds, MEM_WAIT wins and halt_req is re-sampled on return to RUN.
- **MEM_WAIT:**
  - All enables 0, no flush. branch_taken and load_use are ignored, because the pipeline is frozen and the inputs are stable.
  - mem_ready=1: this cycle's outputs follow the RUN rules (cases 2–4) so the pipeline advances; next state is RUN.
  - Wait counter reaches MEM_TIMEOUT without mem_ready: treat the cycle as if mem_ready=1 (advance, go to RUN), pulse mem_err, set mem_err_sticky.
  - Wait counter increments every cycle spent in MEM_WAIT.
- **HALT:**
  - All enables 0, no flush, halted=1.
  - resume=1: next state is RUN, and halted=0 from the next cycle.
  - halt_req is ignored while in HALT.
- **stall_cnt** increments in any RUN or MEM_WAIT cycle with pc_en=0. It does not count in INIT or HALT.
- **Counters** saturate; there is no wrap.

Decomposition:
- Shared package / `define header `pipe_ctrl_defs`, holding:
  - state encoding: INIT=2'd0, RUN=2'd1, MEM_WAIT=2'd2, HALT=2'd3;
  - enable/flush bit ordering for a packed control bus.
- One sub-module is natural: `sat_counter` (parameter W; inputs clk, rst_n, inc; output count), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- **Reset release:** hold rst_n=0 for 3 cycles, then release → both flushes=1 and all enables 0 for exactly 4 cycles, then pc_en=1 on cycle 5; all counters 0.
- **Load-use:** load_use=1 for one RUN cycle → that cycle pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1; next cycle all enables 1; stall_cnt=1.
- **Branch vs load-use:** branch_taken=1 and load_use=1 together → pc_en=1, if_id_flush=1, id_ex_flush=1; flush_cnt=1; stall_cnt unchanged.
- **Memory wait:** mem_req=1 with mem_ready=0 for 3 cycles, then mem_ready=1 → enables 0 for 3 cycles, advance on the 4th, back in RUN; stall_cnt=3; mem_err never set.
- **Memory timeout:** mem_req=1, mem_ready held 0 (MEM_TIMEOUT=16) → forced advance on cycle 16; mem_err high for 1 cycle; mem_err_sticky stays 1 until reset.
- **Halt/resume and saturation:**
  - halt_req pulse → current cycle advances; halted=1 from the next cycle with enables 0; resume → RUN.
  - With CNT_W=4, 20 load_use cycles → stall_cnt holds at 15.
